// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 datapath arbiter.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/data bundle between four requesters, the arbiter and the consumer.
interface mux4_rr_arbiter_if
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = 16
);

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] din_0;
  logic [DATA_W-1:0] din_1;
  logic [DATA_W-1:0] din_2;
  logic [DATA_W-1:0] din_3;
  logic [N_REQ-1:0]  gnt;
  logic [SEL_W-1:0]  sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Arbiter side: owns grant, select and the downstream stream.
  modport master (
    input  req, din_0, din_1, din_2, din_3, out_ready,
    output gnt, sel, out_valid, out_data
  );

  // Environment side: requesters plus the downstream consumer.
  modport slave (
    output req, din_0, din_1, din_2, din_3, out_ready,
    input  gnt, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module mux4_rr_arbiter_rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Scan last+1, last+2, ... (mod 4); the previous owner is checked last.
  always_comb begin
    winner  = last;
    any     = |req;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = last + SEL_W'(k);
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data select among four requesters,
// with a per-grant beat cap so no requester can hog the path.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.master  bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_last;
  logic [N_REQ-1:0]  r_gnt;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic [SEL_W-1:0]  w_winner;
  logic              w_any;
  logic              w_out_valid;
  logic              w_beat;
  logic              w_cap_hit;
  logic              w_release;
  logic [DATA_W-1:0] w_mux;
  logic [DATA_W-1:0] w_out_data;

  mux4_rr_arbiter_rr_pick u_rr_pick (
    .req    (bus.req),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> ARB on any request, ARB -> BURST on a winner,
  // BURST releases back to ARB (or IDLE when nobody is asking).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_any ? ARB : IDLE;
      ARB:     w_state_next = w_any ? BURST : IDLE;
      BURST: begin
        if (w_release) begin
          w_state_next = w_any ? ARB : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: stream is valid only while the granted requester holds req;
  // release on req drop or on the beat that reaches the burst cap.
  always_comb begin
    w_out_valid = (r_state == BURST) && bus.req[r_sel];
    w_beat      = w_out_valid && bus.out_ready;
    w_cap_hit   = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    w_release   = (r_state == BURST) && (!bus.req[r_sel] || (w_beat && w_cap_hit));
    case (r_sel)
      2'd0:    w_mux = bus.din_0;
      2'd1:    w_mux = bus.din_1;
      2'd2:    w_mux = bus.din_2;
      default: w_mux = bus.din_3;
    endcase
    w_out_data = w_mux & {DATA_W{w_out_valid}};
  end

  // Grant/select/counter/history registers; sel only moves on ARB -> BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= '0;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
      r_last     <= 2'd3;
    end else begin
      case (r_state)
        ARB: begin
          if (w_any) begin
            r_sel      <= w_winner;
            r_gnt      <= onehot(w_winner);
            r_beat_cnt <= '0;
          end else begin
            r_gnt <= '0;
          end
        end
        BURST: begin
          if (w_release) begin
            r_last <= r_sel;
            r_gnt  <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (MAX_BURST=4 and MAX_BURST=1 builds).
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mux4_rr_arbiter_if #(.DATA_W(16)) bus_a ();
  mux4_rr_arbiter_if #(.DATA_W(16)) bus_b ();

  mux4_rr_arbiter #(.DATA_W(16), .MAX_BURST(4), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mux4_rr_arbiter #(.DATA_W(16), .MAX_BURST(1), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic [15:0] d);
    chk({tag, ".gnt"},       32'(bus_a.gnt),       32'(g));
    chk({tag, ".sel"},       32'(bus_a.sel),       32'(s));
    chk({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(bus_a.out_data),  32'(d));
    $display("txn %-14s gnt=%b sel=%0d valid=%b data=%h", tag,
             bus_a.gnt, bus_a.sel, bus_a.out_valid, bus_a.out_data);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order_a[5];
    int order_b[4];
    logic [15:0] exp_d;

    clk      = 1'b0;
    rst      = 1'b1;
    n_checks = 0;
    n_errors = 0;
    bus_a.req = 4'b0000; bus_a.out_ready = 1'b0;
    bus_a.din_0 = 16'h1111; bus_a.din_1 = 16'h2222;
    bus_a.din_2 = 16'h3333; bus_a.din_3 = 16'h4444;
    bus_b.req = 4'b0000; bus_b.out_ready = 1'b0;
    bus_b.din_0 = 16'h000A; bus_b.din_1 = 16'h000B;
    bus_b.din_2 = 16'h000C; bus_b.din_3 = 16'h000D;

    // Reset state
    tick();
    tick();
    chk_a("reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
    chk("reset_b.gnt", 32'(bus_b.gnt), 32'd0);

    // Lone requester 0: two-cycle latency, 4 beats, one bubble, regrant
    bus_a.din_0 = 16'hA5A5;
    bus_a.out_ready = 1'b1;
    rst = 1'b0;
    bus_a.req = 4'b0001;
    tick();
    chk_a("t1_arb", 4'b0000, 2'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("t1_beat%0d", i), 4'b0001, 2'd0, 1'b1, 16'hA5A5);
    end
    tick();
    chk_a("t1_bubble", 4'b0000, 2'd0, 1'b0, 16'h0000);
    tick();
    chk_a("t1_regrant", 4'b0001, 2'd0, 1'b1, 16'hA5A5);
    bus_a.req = 4'b0000;
    #1;
    chk_a("t1_drop", 4'b0001, 2'd0, 1'b0, 16'h0000);
    tick();
    chk_a("t1_rel_idle", 4'b0000, 2'd0, 1'b0, 16'h0000);
    tick();
    chk_a("t1_idle", 4'b0000, 2'd0, 1'b0, 16'h0000);

    // All four requesting: order 0,1,2,3,0 with 4 beats each and one bubble
    reset_dut();
    bus_a.din_0 = 16'h1111;
    bus_a.req = 4'b1111;
    order_a = '{0, 1, 2, 3, 0};
    tick();
    chk_a("t2_arb", 4'b0000, 2'd0, 1'b0, 16'h0000);
    for (int n = 0; n < 5; n++) begin
      exp_d = 16'(16'h1111 * (order_a[n] + 1));
      for (int b = 0; b < 4; b++) begin
        tick();
        chk_a($sformatf("t2_g%0d_b%0d", n, b), 4'(1 << order_a[n]), 2'(order_a[n]), 1'b1, exp_d);
      end
      tick();
      chk_a($sformatf("t2_bub%0d", n), 4'b0000, 2'(order_a[n]), 1'b0, 16'h0000);
    end

    // Stall: requester 2 held for 10 cycles with out_ready low, then 4 beats
    reset_dut();
    bus_a.req = 4'b0100;
    bus_a.out_ready = 1'b0;
    tick();
    chk_a("t3_arb", 4'b0000, 2'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a($sformatf("t3_stall%0d", i), 4'b0100, 2'd2, 1'b1, 16'h3333);
    end
    bus_a.out_ready = 1'b1;
    #1;
    chk_a("t3_beat0", 4'b0100, 2'd2, 1'b1, 16'h3333);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_a($sformatf("t3_beat%0d", i), 4'b0100, 2'd2, 1'b1, 16'h3333);
    end
    tick();
    chk_a("t3_release", 4'b0000, 2'd2, 1'b0, 16'h0000);

    // Requester 1 drops after 2 beats; 3 beats 0 because last=1
    reset_dut();
    bus_a.req = 4'b1010;
    tick();
    chk_a("t4_arb", 4'b0000, 2'd0, 1'b0, 16'h0000);
    tick();
    chk_a("t4_beat0", 4'b0010, 2'd1, 1'b1, 16'h2222);
    tick();
    chk_a("t4_beat1", 4'b0010, 2'd1, 1'b1, 16'h2222);
    tick();
    bus_a.req = 4'b1001;
    #1;
    chk_a("t4_drop", 4'b0010, 2'd1, 1'b0, 16'h0000);
    tick();
    chk_a("t4_bubble", 4'b0000, 2'd1, 1'b0, 16'h0000);
    tick();
    chk_a("t4_gnt3", 4'b1000, 2'd3, 1'b1, 16'h4444);

    // Async reset mid-burst clears outputs at once; first grant after goes to 1
    rst = 1'b1;
    #1;
    chk_a("t5_rst_now", 4'b0000, 2'd0, 1'b0, 16'h0000);
    bus_a.req = 4'b0010;
    tick();
    chk_a("t5_rst_hold", 4'b0000, 2'd0, 1'b0, 16'h0000);
    rst = 1'b0;
    tick();
    chk_a("t5_arb", 4'b0000, 2'd0, 1'b0, 16'h0000);
    tick();
    chk_a("t5_gnt1", 4'b0010, 2'd1, 1'b1, 16'h2222);

    // MAX_BURST=1 build: req=0101 alternates 0,2,0,2 one beat each
    reset_dut();
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0101;
    bus_b.out_ready = 1'b1;
    order_b = '{0, 2, 0, 2};
    tick();
    chk("t6_arb.gnt", 32'(bus_b.gnt), 32'd0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t6_g%0d.gnt", n), 32'(bus_b.gnt), 32'(4'(1 << order_b[n])));
      chk($sformatf("t6_g%0d.data", n), 32'(bus_b.out_data), 32'(order_b[n] == 0 ? 16'h000A : 16'h000C));
      $display("txn t6_g%0d gnt=%b data=%h", n, bus_b.gnt, bus_b.out_data);
      tick();
      chk($sformatf("t6_bub%0d.gnt", n), 32'(bus_b.gnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
